// File: rtl/bbox_if.sv
// bbox_if
//  Pixel-stream input and bounding-box result handshake of bbox_detector.
//  slave  : detector side. Consumes en/pix_valid/pix_sof/pix_fg and box_ready.
//           Produces box_top/bottom/left/right, box_found, box_valid,
//           frame_err, overrun and busy.
//  master : environment side, the mirror image of slave.
interface bbox_if #(
  parameter int COORD_W = 10
);
  logic               en;
  logic               pix_valid;
  logic               pix_sof;
  logic               pix_fg;
  logic [COORD_W-1:0] box_top;
  logic [COORD_W-1:0] box_bottom;
  logic [COORD_W-1:0] box_left;
  logic [COORD_W-1:0] box_right;
  logic               box_found;
  logic               box_valid;
  logic               box_ready;
  logic               frame_err;
  logic               overrun;
  logic               busy;

  modport slave (
    input  en, pix_valid, pix_sof, pix_fg, box_ready,
    output box_top, box_bottom, box_left, box_right, box_found, box_valid,
           frame_err, overrun, busy
  );

  modport master (
    output en, pix_valid, pix_sof, pix_fg, box_ready,
    input  box_top, box_bottom, box_left, box_right, box_found, box_valid,
           frame_err, overrun, busy
  );
endinterface

// File: rtl/bbox_detector.sv
// bbox_detector
//  Single-pass bounding-box finder for a raster-ordered binary image stream.
//  Rows with fewer than ROW_THR foreground pixels are treated as noise. The
//  first contiguous run of active rows gives top/bottom, the min/max
//  foreground column inside that run gives left/right. The box is padded by
//  MARGIN on every side, clamped to the image, and offered on a valid/ready
//  handshake.
//  Ports: clk (rising edge), rst (asynchronous, active low), bus (bbox_if
//  slave modport: pixel input, box result, frame_err, overrun, busy).
module bbox_detector #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int COORD_W = 10,
  parameter int ROW_THR = 4,
  parameter int MARGIN  = 5
) (
  input logic   clk,
  input logic   rst,
  bbox_if.slave bus
);
  localparam int CNT_W = $clog2(IMG_W + 1);
  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_H - 1);
  localparam logic [COORD_W-1:0] ZERO_C   = {COORD_W{1'b0}};
  localparam logic [COORD_W-1:0] ONE_C    = COORD_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEARCH   = 2'd1,
    IN_OBJ   = 2'd2,
    DONE_OBJ = 2'd3
  } state_t;

  // Subtract the margin, clamping at zero instead of wrapping.
  function automatic logic [COORD_W-1:0] pad_lo(input logic [COORD_W-1:0] v);
    int s;
    s = int'(v) - MARGIN;
    return (s < 0) ? ZERO_C : COORD_W'(s);
  endfunction

  // Add the margin, clamping at the last valid coordinate lim.
  function automatic logic [COORD_W-1:0] pad_hi(input logic [COORD_W-1:0] v, input int lim);
    int s;
    s = int'(v) + MARGIN;
    return (s > lim) ? COORD_W'(lim) : COORD_W'(s);
  endfunction

  state_t             state_r, state_s;
  logic [COORD_W-1:0] col_r, col_s, row_r, row_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s, pcnt_s;
  logic [COORD_W-1:0] rmin_r, rmin_s, rmax_r, rmax_s, pmin_s, pmax_s;
  logic [COORD_W-1:0] top_r, top_s, bot_r, bot_s, left_r, left_s, right_r, right_s;
  logic               found_r, found_s;
  logic               acc_s, proc_s, row_act_s, done_s, err_s;
  logic [COORD_W-1:0] res_top_s, res_bot_s, res_left_s, res_right_s;

  logic [COORD_W-1:0] box_top_r, box_bot_r, box_left_r, box_right_r;
  logic               box_found_r, box_valid_r, frame_err_r, overrun_r, busy_r;

  assign acc_s = bus.en && bus.pix_valid;

  // Next-state: position tracking, per-row accumulation and box extents.
  always_comb begin
    state_s   = state_r;
    col_s     = col_r;
    row_s     = row_r;
    cnt_s     = cnt_r;
    rmin_s    = rmin_r;
    rmax_s    = rmax_r;
    top_s     = top_r;
    bot_s     = bot_r;
    left_s    = left_r;
    right_s   = right_r;
    found_s   = found_r;
    pcnt_s    = cnt_r;
    pmin_s    = rmin_r;
    pmax_s    = rmax_r;
    row_act_s = 1'b0;
    done_s    = 1'b0;
    err_s     = 1'b0;
    proc_s    = 1'b0;

    // A start-of-frame pixel always restarts at (0,0), aborting any partial frame.
    if (acc_s && bus.pix_sof) begin
      err_s   = (state_r != IDLE);
      state_s = SEARCH;
      col_s   = ZERO_C;
      row_s   = ZERO_C;
      cnt_s   = {CNT_W{1'b0}};
      rmin_s  = LAST_COL;
      rmax_s  = ZERO_C;
      top_s   = ZERO_C;
      bot_s   = ZERO_C;
      left_s  = ZERO_C;
      right_s = ZERO_C;
      found_s = 1'b0;
      proc_s  = 1'b1;
    end else begin
      proc_s = acc_s && (state_r != IDLE);
    end

    if (proc_s) begin
      // Row statistics including the current pixel.
      pcnt_s = (&cnt_s) ? cnt_s : cnt_s + CNT_W'(bus.pix_fg);
      pmin_s = (bus.pix_fg && (col_s < rmin_s)) ? col_s : rmin_s;
      pmax_s = (bus.pix_fg && (col_s > rmax_s)) ? col_s : rmax_s;
      if (col_s == LAST_COL) begin
        row_act_s = (pcnt_s >= CNT_W'(ROW_THR));
        case (state_s)
          SEARCH: begin
            if (row_act_s) begin
              state_s = IN_OBJ;
              found_s = 1'b1;
              top_s   = row_s;
              left_s  = pmin_s;
              right_s = pmax_s;
            end else begin
              state_s = SEARCH;
            end
          end
          IN_OBJ: begin
            if (row_act_s) begin
              left_s  = (pmin_s < left_s) ? pmin_s : left_s;
              right_s = (pmax_s > right_s) ? pmax_s : right_s;
            end else begin
              // Cannot underflow: the object's top row ended earlier.
              bot_s   = row_s - ONE_C;
              state_s = DONE_OBJ;
            end
          end
          default: begin
            state_s = state_s;
          end
        endcase
        if (row_s == LAST_ROW) begin
          if (state_s == IN_OBJ) begin
            bot_s = LAST_ROW;
          end else begin
            bot_s = bot_s;
          end
          state_s = IDLE;
          done_s  = 1'b1;
          row_s   = ZERO_C;
        end else begin
          row_s = row_s + ONE_C;
        end
        col_s  = ZERO_C;
        cnt_s  = {CNT_W{1'b0}};
        rmin_s = LAST_COL;
        rmax_s = ZERO_C;
      end else begin
        col_s  = col_s + ONE_C;
        cnt_s  = pcnt_s;
        rmin_s = pmin_s;
        rmax_s = pmax_s;
      end
    end else begin
      pcnt_s = cnt_s;
    end
  end

  // Margin padding and clamping of the finished box; an empty frame reports zeros.
  always_comb begin
    res_top_s   = ZERO_C;
    res_bot_s   = ZERO_C;
    res_left_s  = ZERO_C;
    res_right_s = ZERO_C;
    if (found_s) begin
      res_top_s   = pad_lo(top_s);
      res_bot_s   = pad_hi(bot_s, IMG_H - 1);
      res_left_s  = pad_lo(left_s);
      res_right_s = pad_hi(right_s, IMG_W - 1);
    end else begin
      res_top_s   = ZERO_C;
      res_bot_s   = ZERO_C;
      res_left_s  = ZERO_C;
      res_right_s = ZERO_C;
    end
  end

  // Frame-tracking state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      col_r   <= ZERO_C;
      row_r   <= ZERO_C;
      cnt_r   <= {CNT_W{1'b0}};
      rmin_r  <= LAST_COL;
      rmax_r  <= ZERO_C;
      top_r   <= ZERO_C;
      bot_r   <= ZERO_C;
      left_r  <= ZERO_C;
      right_r <= ZERO_C;
      found_r <= 1'b0;
    end else begin
      state_r <= state_s;
      col_r   <= col_s;
      row_r   <= row_s;
      cnt_r   <= cnt_s;
      rmin_r  <= rmin_s;
      rmax_r  <= rmax_s;
      top_r   <= top_s;
      bot_r   <= bot_s;
      left_r  <= left_s;
      right_r <= right_s;
      found_r <= found_s;
    end
  end

  // Result handshake, sticky overrun and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      box_top_r   <= ZERO_C;
      box_bot_r   <= ZERO_C;
      box_left_r  <= ZERO_C;
      box_right_r <= ZERO_C;
      box_found_r <= 1'b0;
      box_valid_r <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      frame_err_r <= err_s;
      busy_r      <= (state_s != IDLE);
      if (done_s) begin
        // A result still waiting for the consumer wins over the new one.
        if (box_valid_r && !bus.box_ready) begin
          overrun_r <= 1'b1;
        end else begin
          box_valid_r <= 1'b1;
          box_found_r <= found_s;
          box_top_r   <= res_top_s;
          box_bot_r   <= res_bot_s;
          box_left_r  <= res_left_s;
          box_right_r <= res_right_s;
        end
      end else if (box_valid_r && bus.box_ready) begin
        box_valid_r <= 1'b0;
        box_found_r <= 1'b0;
        box_top_r   <= ZERO_C;
        box_bot_r   <= ZERO_C;
        box_left_r  <= ZERO_C;
        box_right_r <= ZERO_C;
      end
    end
  end

  assign bus.box_top    = box_top_r;
  assign bus.box_bottom = box_bot_r;
  assign bus.box_left   = box_left_r;
  assign bus.box_right  = box_right_r;
  assign bus.box_found  = box_found_r;
  assign bus.box_valid  = box_valid_r;
  assign bus.frame_err  = frame_err_r;
  assign bus.overrun    = overrun_r;
  assign bus.busy       = busy_r;
endmodule
